status_flag_unit: RTL and testbench

- Consumer end of the ALU flag interface. Captures the 4-bit {Z, C, S, O} flag vector the ALU emits into the architectural Status Register (SR).
- Applies a per-mode update mask so logical, buffer and shift ops preserve C/O.
- Holds a small LIFO of saved SR values for interrupt/call entry and exit.
- Evaluates the branch condition the control unit requests from the registered SR.

---
 rtl/status_flag_unit_pkg.sv | 43 ++++
 rtl/status_flag_unit_sr_stack.sv | 55 +++++
 rtl/status_flag_unit.sv | 86 ++++++++
 tb/tb_status_flag_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/status_flag_unit_pkg.sv
// Shared flag-interface definitions: flag bit positions, ALU mode and branch
// condition encodings, and the arithmetic-mode predicate used for flag masking.
package status_flag_unit_pkg;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_O = 0;

  localparam logic [3:0] MODE_ADD = 4'b0000;
  localparam logic [3:0] MODE_ADC = 4'b0001;
  localparam logic [3:0] MODE_OR  = 4'b0010;
  localparam logic [3:0] MODE_XOR = 4'b0011;
  localparam logic [3:0] MODE_AND = 4'b0100;
  localparam logic [3:0] MODE_NOT = 4'b0101;
  localparam logic [3:0] MODE_BUF = 4'b0110;
  localparam logic [3:0] MODE_SUB = 4'b0111;
  localparam logic [3:0] MODE_SBB = 4'b1000;
  localparam logic [3:0] MODE_CMP = 4'b1001;
  localparam logic [3:0] MODE_SHL = 4'b1010;
  localparam logic [3:0] MODE_SHR = 4'b1011;
  localparam logic [3:0] MODE_SAR = 4'b1100;
  localparam logic [3:0] MODE_ROL = 4'b1101;
  localparam logic [3:0] MODE_ROR = 4'b1110;
  localparam logic [3:0] MODE_NEG = 4'b1111;

  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_Z      = 3'b001;
  localparam logic [2:0] COND_NZ     = 3'b010;
  localparam logic [2:0] COND_C      = 3'b011;
  localparam logic [2:0] COND_NC     = 3'b100;
  localparam logic [2:0] COND_S      = 3'b101;
  localparam logic [2:0] COND_O      = 3'b110;
  localparam logic [2:0] COND_LT     = 3'b111;

  // Bit n set means mode n produces meaningful C/O (ADD, ADC, SUB, SBB, CMP, NEG).
  localparam logic [15:0] ARITH_MODE_MASK = 16'h8383;

  function automatic logic is_arith_mode(input logic [3:0] mode);
    return ARITH_MODE_MASK[mode];
  endfunction

endpackage

// File: rtl/status_flag_unit_sr_stack.sv
// Parameterised LIFO of saved status-register values with sticky error on
// overflow, underflow or a simultaneous push/pop request.
module sr_stack #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_top,
  output logic         o_pop_ok,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_err
);

  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [W-1:0]   r_slot [DEPTH];
  logic [PTR_W:0] r_count;
  logic           r_err;
  logic           w_push_ok;
  logic           w_err_evt;
  logic [PTR_W-1:0] w_top_idx;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push & ~i_pop & ~o_full;
  assign o_pop_ok  = i_pop & ~i_push & ~o_empty;
  assign w_err_evt = (i_push & i_pop) | (i_push & ~i_pop & o_full) | (i_pop & ~i_push & o_empty);
  // Low bits wrap to DEPTH-1 when full, which is exactly the top slot.
  assign w_top_idx = r_count[PTR_W-1:0] - PTR_W'(1);
  assign o_top     = r_slot[w_top_idx];
  assign o_err     = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
    end else begin
      if (w_err_evt) r_err <= 1'b1;
      if (w_push_ok) begin
        r_slot[r_count[PTR_W-1:0]] <= i_data;
        r_count <= r_count + 1'b1;
      end else if (o_pop_ok) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/status_flag_unit.sv
// Status register at the consumer end of the ALU flag interface: masked flag
// capture, direct load, save/restore stack and branch-condition evaluation.
module status_flag_unit
  import status_flag_unit_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int PTR_W       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_E,
  input  logic [3:0] alu_mode,
  input  logic [3:0] alu_flags,
  input  logic       wr_en,
  input  logic [3:0] wr_data,
  input  logic       push,
  input  logic       pop,
  input  logic [2:0] cond_sel,
  output logic [3:0] SR,
  output logic       cond_true,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       stack_err
);

  logic [3:0] r_sr;
  logic [3:0] w_top;
  logic       w_pop_ok;
  logic [3:0] w_captured;

  sr_stack #(
    .DEPTH(STACK_DEPTH),
    .PTR_W(PTR_W),
    .W    (4)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (push),
    .i_pop   (pop),
    .i_data  (r_sr),
    .o_top   (w_top),
    .o_pop_ok(w_pop_ok),
    .o_full  (stack_full),
    .o_empty (stack_empty),
    .o_err   (stack_err)
  );

  // Non-arithmetic ops leave C and O untouched.
  always_comb begin
    w_captured = alu_flags;
    if (!is_arith_mode(alu_mode)) begin
      w_captured[FLAG_C] = r_sr[FLAG_C];
      w_captured[FLAG_O] = r_sr[FLAG_O];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= 4'b0000;
    end else if (w_pop_ok) begin
      r_sr <= w_top;
    end else if (wr_en) begin
      r_sr <= wr_data;
    end else if (alu_E) begin
      r_sr <= w_captured;
    end
  end

  always_comb begin
    cond_true = 1'b1;
    unique case (cond_sel)
      COND_ALWAYS: cond_true = 1'b1;
      COND_Z:      cond_true = r_sr[FLAG_Z];
      COND_NZ:     cond_true = ~r_sr[FLAG_Z];
      COND_C:      cond_true = r_sr[FLAG_C];
      COND_NC:     cond_true = ~r_sr[FLAG_C];
      COND_S:      cond_true = r_sr[FLAG_S];
      COND_O:      cond_true = r_sr[FLAG_O];
      COND_LT:     cond_true = r_sr[FLAG_S] ^ r_sr[FLAG_O];
      default:     cond_true = 1'b1;
    endcase
  end

  assign SR = r_sr;

endmodule

// File: tb/tb_status_flag_unit.sv
// Scoreboard bench: stimulus pushes model predictions into a queue, a monitor
// pops and compares them one cycle after each capturing edge.
module tb_status_flag_unit;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       alu_E;
  logic [3:0] alu_mode;
  logic [3:0] alu_flags;
  logic       wr_en;
  logic [3:0] wr_data;
  logic       push;
  logic       pop;
  logic [2:0] cond_sel;
  logic [3:0] SR;
  logic       cond_true;
  logic       stack_full;
  logic       stack_empty;
  logic       stack_err;

  typedef struct {
    logic [3:0] sr;
    logic       full;
    logic       empty;
    logic       err;
    logic       cond;
  } exp_t;

  exp_t       expQ[$];
  int         total = 0;
  int         bad = 0;
  logic [3:0] mSr;
  logic [3:0] mStk[$];
  logic       mErr;
  int         arithModes[6] = '{0, 1, 7, 8, 9, 15};

  status_flag_unit #(.STACK_DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_E      (alu_E),
    .alu_mode   (alu_mode),
    .alu_flags  (alu_flags),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .push       (push),
    .pop        (pop),
    .cond_sel   (cond_sel),
    .SR         (SR),
    .cond_true  (cond_true),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .stack_err  (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic isArith(input logic [3:0] m);
    for (int i = 0; i < 6; i++) if (int'(m) == arithModes[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Branch condition over {Z,C,S,O}.
  function automatic logic condOf(input logic [2:0] sel, input logic [3:0] s);
    logic z, c, sg, o;
    {z, c, sg, o} = s;
    case (sel)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return c;
      3'd4: return !c;
      3'd5: return sg;
      3'd6: return o;
      default: return sg != o;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic aE, input logic [3:0] mode, input logic [3:0] flags,
                               input logic wE, input logic [3:0] wD,
                               input logic pu, input logic po, input logic [2:0] cs);
    exp_t e;
    logic [3:0] nextSr;
    logic pushOk, popOk;
    @(negedge clk);
    alu_E = aE; alu_mode = mode; alu_flags = flags;
    wr_en = wE; wr_data = wD; push = pu; pop = po; cond_sel = cs;
    pushOk = pu && !po && (mStk.size() < DEPTH);
    popOk  = po && !pu && (mStk.size() > 0);
    if ((pu && po) || (pu && !po && mStk.size() == DEPTH) || (po && !pu && mStk.size() == 0))
      mErr = 1'b1;
    nextSr = mSr;
    if (popOk) nextSr = mStk.pop_back();
    else if (wE) nextSr = wD;
    else if (aE) nextSr = isArith(mode) ? flags : ((flags & 4'b1010) | (mSr & 4'b0101));
    if (pushOk) mStk.push_back(mSr);
    mSr = nextSr;
    e.sr = mSr;
    e.full = (mStk.size() == DEPTH);
    e.empty = (mStk.size() == 0);
    e.err = mErr;
    e.cond = condOf(cs, mSr);
    expQ.push_back(e);
  endtask

  task automatic idle(input logic [2:0] cs);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, cs);
  endtask

  task automatic loadSr(input logic [3:0] v);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, v, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic checkResetState();
    checkOutput("rst_sr", SR, 4'b0000);
    checkOutput("rst_empty", {3'b0, stack_empty}, 4'd1);
    checkOutput("rst_full", {3'b0, stack_full}, 4'd0);
    checkOutput("rst_err", {3'b0, stack_err}, 4'd0);
    checkOutput("rst_cond", {3'b0, cond_true}, {3'b0, condOf(cond_sel, 4'b0000)});
  endtask

  // Asynchronous reset pulsed between edges; state must clear without a clock.
  task automatic doReset();
    @(negedge clk);
    alu_E = 1'b0; wr_en = 1'b0; push = 1'b0; pop = 1'b0;
    cond_sel = 3'($urandom_range(0, 7));
    #2 rst_n = 1'b0;
    #1 checkResetState();
    mSr = 4'b0000; mStk.delete(); mErr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("sr", SR, e.sr);
        checkOutput("full", {3'b0, stack_full}, {3'b0, e.full});
        checkOutput("empty", {3'b0, stack_empty}, {3'b0, e.empty});
        checkOutput("err", {3'b0, stack_err}, {3'b0, e.err});
        checkOutput("cond", {3'b0, cond_true}, {3'b0, e.cond});
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0;
    alu_E = 1'b0; alu_mode = 4'd0; alu_flags = 4'd0;
    wr_en = 1'b0; wr_data = 4'd0; push = 1'b0; pop = 1'b0; cond_sel = 3'd0;
    mSr = 4'b0000; mErr = 1'b0;
    #1 checkResetState();
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b1, 4'b0000, 4'b0100, 1'b0, 4'd0, 1'b0, 1'b0, 3'b011);
    idle(3'b011);
    idle(3'b001);

    loadSr(4'b0101);
    applyStimulus(1'b1, 4'b0100, 4'b1010, 1'b0, 4'd0, 1'b0, 1'b0, 3'b111);
    idle(3'b111);

    loadSr(4'b0011);
    applyStimulus(1'b1, 4'b0000, 4'b1000, 1'b0, 4'd0, 1'b1, 1'b0, 3'b001);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 3'b011);

    for (int i = 0; i < 4; i++) begin
      loadSr(4'(1 << i));
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd0);
    end
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 3'($urandom_range(0, 7)));

    doReset();
    applyStimulus(1'b1, 4'b0001, 4'b0110, 1'b0, 4'd0, 1'b0, 1'b1, 3'b110);
    loadSr(4'b1001);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd0);
    applyStimulus(1'b1, 4'b0011, 4'b1111, 1'b0, 4'd0, 1'b1, 1'b1, 3'b111);

    doReset();
    loadSr(4'b1100);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd0);
    doReset();

    for (int n = 0; n < 400; n++) begin
      if (n % 80 == 79) doReset();
      else applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                         ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                         ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                         3'($urandom_range(0, 7)));
    end

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: %0d pending, expected 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
